// File: rtl/conv_feed_pkg.sv
// Shared constants, types and config decode for the CONV lane-stream feeder.
// Defaults here match the CONV top; the feeder re-derives sizes from its own parameters.
package conv_feed_pkg;

    localparam int unsigned DEF_DW   = 8;
    localparam int unsigned DEF_K    = 4;
    localparam int unsigned DEF_FMAP = 64;
    localparam int unsigned DEF_COLS = 2;
    localparam int unsigned DEF_AW   = 16;

    localparam int unsigned LANES    = DEF_K * DEF_COLS;
    localparam int unsigned KBEATS   = (DEF_K * DEF_K) / LANES;
    localparam int unsigned ROWPOS   = DEF_FMAP - DEF_K + 1;
    localparam int unsigned COLBEATS = DEF_FMAP / DEF_COLS;

    // Channel/kernel counters hold up to 32
    localparam int unsigned CNT_W = 6;

    typedef enum logic {
        BEAT_KERN = 1'b0,
        BEAT_FMAP = 1'b1
    } beat_kind_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_KERN  = 2'd1,
        ST_FMAP  = 2'd2,
        ST_DRAIN = 2'd3
    } feed_state_e;

    typedef struct packed {
        beat_kind_e kind;
        logic       last;
    } beat_tag_t;

    // 0->8, 1->16, 2->24, 3 and above->32
    function automatic logic [CNT_W-1:0] cfg_to_count(input logic [2:0] cfg);
        logic [1:0] idx;
        idx = (cfg > 3'd3) ? 2'd3 : cfg[1:0];
        return CNT_W'({idx, 3'b000}) + CNT_W'(8);
    endfunction

endpackage

// File: rtl/feed_skid_fifo.sv
// Two-entry FIFO decoupling memory read returns from the downstream handshake.
// Simultaneous push and pop keeps occupancy and order.
module feed_skid_fifo #(
    parameter int unsigned W = 66
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end

endmodule

// File: rtl/conv_stream_feeder.sv
// Walks kernel/channel/row/column loops, reads kernel and fmap memories and emits
// the CONV lane stream with valid/ready backpressure and start/busy/done control.
module conv_stream_feeder
    import conv_feed_pkg::*;
#(
    parameter int unsigned DW   = DEF_DW,
    parameter int unsigned K    = DEF_K,
    parameter int unsigned FMAP = DEF_FMAP,
    parameter int unsigned COLS = DEF_COLS,
    parameter int unsigned AW   = DEF_AW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            cfg_ci,
    input  logic [2:0]            cfg_co,
    output logic                  busy,
    output logic                  done,
    output logic [AW-1:0]         kn_addr,
    input  logic [K*COLS*DW-1:0]  kn_rdata,
    output logic [K*AW-1:0]       fm_addr,
    input  logic [K*COLS*DW-1:0]  fm_rdata,
    output logic                  rd_en,
    output logic                  o_valid,
    input  logic                  o_ready,
    output logic [K*COLS*DW-1:0]  o_data,
    output logic                  o_kind,
    output logic                  o_last
);

    localparam int unsigned N_LANES    = K * COLS;
    localparam int unsigned N_KBEATS   = (K * K) / N_LANES;
    localparam int unsigned N_ROWPOS   = FMAP - K + 1;
    localparam int unsigned N_COLBEATS = FMAP / COLS;
    localparam int unsigned BW = (N_KBEATS > 1) ? $clog2(N_KBEATS) : 1;
    localparam int unsigned RW = (N_ROWPOS > 1) ? $clog2(N_ROWPOS) : 1;
    localparam int unsigned JW = (N_COLBEATS > 1) ? $clog2(N_COLBEATS) : 1;
    localparam int unsigned BEAT_W = N_LANES * DW;
    localparam int unsigned FIFO_W = BEAT_W + 2;
    // Address jump from the last window of a channel to row 0 of the next one
    localparam int unsigned CH_STEP = (K - 1) * N_COLBEATS + 1;

    feed_state_e      state, state_n;
    logic [CNT_W-1:0] nci, nci_n, nco, nco_n;
    logic [CNT_W-1:0] kn, kn_n, ch, ch_n;
    logic [BW-1:0]    b, b_n;
    logic [RW-1:0]    r, r_n;
    logic [JW-1:0]    j, j_n;
    logic [AW-1:0]    kaddr, kaddr_n;
    logic [AW-1:0]    faddr [K];
    logic [AW-1:0]    faddr_n [K];
    logic             fa_load;
    logic [AW-1:0]    fa_step;
    logic             busy_n, done_n;
    logic             issue_c, pop_c, room_c;
    logic [2:0]       credit_c;
    beat_tag_t        tag_c, tag_pend;
    logic             rd_pend;
    logic [1:0]       fifo_count;
    logic [FIFO_W-1:0] fifo_wdata, fifo_rdata;
    logic [BEAT_W-1:0] fm_lanes;

    assign o_valid  = (fifo_count != 2'd0);
    assign pop_c    = o_valid && o_ready;
    // Occupancy after this cycle's pop plus the read still returning
    assign credit_c = 3'(fifo_count) + 3'(rd_pend) - 3'(pop_c);
    assign room_c   = (credit_c < 3'd2);
    assign rd_en    = issue_c;
    assign kn_addr  = kaddr;

    for (genvar g = 0; g < K; g++) begin : g_faddr
        assign fm_addr[g*AW +: AW] = faddr[g];
    end

    // Lane c*K+k takes column c of row port k (column-major across rows)
    for (genvar gc = 0; gc < COLS; gc++) begin : g_col
        for (genvar gk = 0; gk < K; gk++) begin : g_row
            assign fm_lanes[(gc*K+gk)*DW +: DW] = fm_rdata[(gk*COLS+gc)*DW +: DW];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        nci_n   = nci;
        nco_n   = nco;
        kn_n    = kn;
        ch_n    = ch;
        b_n     = b;
        r_n     = r;
        j_n     = j;
        kaddr_n = kaddr;
        fa_load = 1'b0;
        fa_step = '0;
        issue_c = 1'b0;
        tag_c   = '{kind: BEAT_KERN, last: 1'b0};
        done_n  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_n = ST_KERN;
                    nci_n   = cfg_to_count(cfg_ci);
                    nco_n   = cfg_to_count(cfg_co);
                    kn_n    = '0;
                    ch_n    = '0;
                    b_n     = '0;
                    r_n     = '0;
                    j_n     = '0;
                    kaddr_n = '0;
                    fa_load = 1'b1;
                end
            end
            ST_KERN: begin
                if (room_c) begin
                    issue_c = 1'b1;
                    kaddr_n = kaddr + AW'(1);
                    if (b == BW'(N_KBEATS - 1)) begin
                        b_n     = '0;
                        state_n = ST_FMAP;
                    end else begin
                        b_n = b + BW'(1);
                    end
                end
            end
            ST_FMAP: begin
                if (room_c) begin
                    issue_c    = 1'b1;
                    tag_c.kind = BEAT_FMAP;
                    fa_step    = AW'(1);
                    if (j != JW'(N_COLBEATS - 1)) begin
                        j_n = j + JW'(1);
                    end else begin
                        j_n = '0;
                        if (r != RW'(N_ROWPOS - 1)) begin
                            r_n = r + RW'(1);
                        end else begin
                            r_n        = '0;
                            tag_c.last = 1'b1;
                            if (ch != nci - CNT_W'(1)) begin
                                ch_n    = ch + CNT_W'(1);
                                fa_step = AW'(CH_STEP);
                                state_n = ST_KERN;
                            end else begin
                                ch_n    = '0;
                                fa_load = 1'b1;
                                if (kn != nco - CNT_W'(1)) begin
                                    kn_n    = kn + CNT_W'(1);
                                    state_n = ST_KERN;
                                end else begin
                                    state_n = ST_DRAIN;
                                end
                            end
                        end
                    end
                end
            end
            ST_DRAIN: begin
                // done is pulsed while still in DRAIN so a start in that cycle is ignored
                if (done) begin
                    state_n = ST_IDLE;
                end else if (!rd_pend &&
                             ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop_c))) begin
                    done_n = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        busy_n = (state_n != ST_IDLE);
    end

    always_comb begin
        for (int k = 0; k < K; k++) begin
            faddr_n[k] = fa_load ? AW'(k * N_COLBEATS) : faddr[k] + fa_step;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nci      <= '0;
            nco      <= '0;
            kn       <= '0;
            ch       <= '0;
            b        <= '0;
            r        <= '0;
            j        <= '0;
            kaddr    <= '0;
            for (int k = 0; k < K; k++) begin
                faddr[k] <= '0;
            end
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_pend  <= 1'b0;
            tag_pend <= '0;
        end else begin
            nci      <= nci_n;
            nco      <= nco_n;
            kn       <= kn_n;
            ch       <= ch_n;
            b        <= b_n;
            r        <= r_n;
            j        <= j_n;
            kaddr    <= kaddr_n;
            for (int k = 0; k < K; k++) begin
                faddr[k] <= faddr_n[k];
            end
            busy     <= busy_n;
            done     <= done_n;
            rd_pend  <= issue_c;
            tag_pend <= tag_c;
        end
    end

    assign fifo_wdata = {tag_pend, (tag_pend.kind == BEAT_FMAP) ? fm_lanes : kn_rdata};

    feed_skid_fifo #(
        .W(FIFO_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rd_pend),
        .pop   (pop_c),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .count (fifo_count)
    );

    assign o_data = fifo_rdata[BEAT_W-1:0];
    assign o_kind = fifo_rdata[FIFO_W-1];
    assign o_last = fifo_rdata[FIFO_W-2];

endmodule

// File: tb/tb_conv_stream_feeder.sv
// Directed bench for conv_stream_feeder on a reduced 8x8 fmap geometry with
// address-derived memory contents and a loop-index reference for every beat.
module tb_conv_stream_feeder;

    localparam int unsigned TDW = 8;
    localparam int unsigned TK = 4;
    localparam int unsigned TFMAP = 8;
    localparam int unsigned TCOLS = 2;
    localparam int unsigned TAW = 16;
    localparam int unsigned TLANES = TK * TCOLS;
    localparam int unsigned TCB = TFMAP / TCOLS;
    localparam int unsigned TROWPOS = TFMAP - TK + 1;
    localparam int unsigned PER_CH = 2 + TROWPOS * TCB;

    logic                   clk;
    logic                   rst;
    logic                   start;
    logic [2:0]             cfg_ci;
    logic [2:0]             cfg_co;
    logic                   busy;
    logic                   done;
    logic [TAW-1:0]         kn_addr;
    logic [TLANES*TDW-1:0]  kn_rdata;
    logic [TK*TAW-1:0]      fm_addr;
    logic [TLANES*TDW-1:0]  fm_rdata;
    logic                   rd_en;
    logic                   o_valid;
    logic                   o_ready;
    logic [TLANES*TDW-1:0]  o_data;
    logic                   o_kind;
    logic                   o_last;

    int checks;
    int failures;
    logic [63:0] cap_data [32];
    logic        cap_kind [32];
    logic        cap_last [32];

    conv_stream_feeder #(
        .DW(TDW), .K(TK), .FMAP(TFMAP), .COLS(TCOLS), .AW(TAW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_ci(cfg_ci), .cfg_co(cfg_co),
        .busy(busy), .done(done), .kn_addr(kn_addr), .kn_rdata(kn_rdata),
        .fm_addr(fm_addr), .fm_rdata(fm_rdata), .rd_en(rd_en),
        .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data),
        .o_kind(o_kind), .o_last(o_last)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] fm_value(input logic [15:0] addr, input int c);
        int a;
        a = int'(addr);
        return 8'((a / 32) * 64 + ((a / 4) % 8) * 8 + (a % 4) * 2 + c);
    endfunction

    // Memories: kernel lane i = 8*addr+i; fmap value = 64*ch + 8*row + col
    always @(posedge clk) begin
        if (rd_en) begin
            for (int i = 0; i < 8; i++) begin
                kn_rdata[i*8 +: 8] <= 8'(int'(kn_addr) * 8 + i);
            end
            for (int k = 0; k < 4; k++) begin
                for (int c = 0; c < 2; c++) begin
                    fm_rdata[(k*2+c)*8 +: 8] <= fm_value(fm_addr[k*16 +: 16], c);
                end
            end
        end
    end

    function automatic logic [65:0] exp_beat(input int idx, input int nci);
        int q, rem, kn, ch, a, f, r, j, row, col;
        logic [63:0] d;
        logic kind, last;
        q = idx / PER_CH;
        rem = idx % PER_CH;
        kn = q / nci;
        ch = q % nci;
        d = '0;
        if (rem < 2) begin
            a = (kn * nci + ch) * 2 + rem;
            for (int i = 0; i < 8; i++) d[i*8 +: 8] = 8'(a * 8 + i);
            kind = 1'b0;
            last = 1'b0;
        end else begin
            f = rem - 2;
            r = f / 4;
            j = f % 4;
            for (int i = 0; i < 8; i++) begin
                row = r + i % 4;
                col = j * 2 + i / 4;
                d[i*8 +: 8] = 8'(ch * 64 + row * 8 + col);
            end
            kind = 1'b1;
            last = (rem == PER_CH - 1);
        end
        return {kind, last, d};
    endfunction

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_run(input logic [2:0] ci, input logic [2:0] co);
        cfg_ci = ci;
        cfg_co = co;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Entered and left at a negedge; counts handshakes against the reference stream
    task automatic consume(input int nci, input int total, input int bp, input int stop_at,
                           input int glitch_cyc, output int got);
        logic        stalled;
        logic [66:0] held;
        logic        rdy;
        int          n;
        n = 0;
        stalled = 1'b0;
        held = '0;
        for (int cyc = 0; cyc < total * 4 + 200; cyc++) begin
            if (cyc == glitch_cyc) begin
                start = 1'b1;
                cfg_ci = 3'd3;
                cfg_co = 3'd3;
            end else begin
                start = 1'b0;
            end
            if (stalled) chk("stall_hold", {o_valid, o_kind, o_last, o_data}, held);
            rdy = (bp == 0) ? 1'b1 : (32'($urandom_range(0, 99)) >= 32'(bp));
            o_ready = rdy;
            if (o_valid && rdy) begin
                chk("beat", {done, o_kind, o_last, o_data}, {1'b0, exp_beat(n, nci)});
                if (bp == 0 && n < 32) begin
                    cap_data[n] = o_data;
                    cap_kind[n] = o_kind;
                    cap_last[n] = o_last;
                end
                n++;
            end
            stalled = o_valid && !rdy;
            held = {1'b1, o_kind, o_last, o_data};
            if (n == total || n == stop_at) break;
            @(negedge clk);
        end
        start = 1'b0;
        got = n;
    endtask

    task automatic finish_run();
        @(negedge clk);
        chk("done_pulse", {done, busy, o_valid}, 3'b110);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("done_fall", {done, busy}, 2'b00);
        repeat (10) @(negedge clk);
        chk("idle_after_done", {busy, o_valid, rd_en}, 3'b000);
    endtask

    initial begin
        int got;
        logic seen;
        checks = 0;
        failures = 0;
        clk = 1'b0;
        rst = 1'b1;
        start = 1'b0;
        cfg_ci = 3'd0;
        cfg_co = 3'd0;
        o_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {busy, done, o_valid, rd_en, o_kind, o_last}, 6'd0);
        chk("reset_addr", {kn_addr, fm_addr}, '0);
        rst = 1'b0;
        seen = 1'b0;
        repeat (100) begin
            @(negedge clk);
            seen = seen | o_valid | busy;
        end
        chk("idle_no_valid", seen, 1'b0);

        // Nominal run with start-up latency
        o_ready = 1'b1;
        start_run(3'd0, 3'd0);
        chk("lat_c1", {rd_en, busy, o_valid, kn_addr}, {3'b110, 16'd0});
        @(negedge clk);
        chk("lat_c2", {rd_en, o_valid, kn_addr}, {2'b10, 16'd1});
        @(negedge clk);
        chk("lat_c3", {rd_en, o_valid, fm_addr}, {2'b11, 64'h000C_0008_0004_0000});
        consume(8, 1408, 0, -1, -1, got);
        chk("nominal_count", got, 1408);
        finish_run();
        chk("nominal_kaddr", kn_addr, 16'd128);
        chk("beat1_lit", cap_data[0], 64'h0706050403020100);
        chk("beat2_lit", {cap_kind[1], cap_data[1]}, {1'b0, 64'h0F0E0D0C0B0A0908});
        chk("beat3_lit", {cap_kind[2], cap_data[2]}, {1'b1, 64'h1911090118100800});
        chk("beat6_lit", cap_data[5], 64'h1F170F071E160E06);
        chk("ch_last", {cap_last[20], cap_last[21]}, 2'b01);
        chk("ch1_kern_lit", {cap_kind[22], cap_data[22]}, {1'b0, 64'h1716151413121110});

        // Reset while idle clears stale output data
        rst = 1'b1;
        #1;
        chk("reset_idle_data", {o_valid, o_data}, '0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Backpressure with a start (new cfg) mid-run that must be ignored
        start_run(3'd0, 3'd0);
        consume(8, 1408, 30, -1, 500, got);
        chk("bp_count", got, 1408);
        finish_run();
        chk("bp_kaddr", kn_addr, 16'd128);

        // Config decode: ci=5 -> 32 channels, co=1 -> 16 kernels
        start_run(3'd5, 3'd1);
        consume(32, 11264, 0, -1, -1, got);
        chk("cfg_count", got, 11264);
        finish_run();
        chk("cfg_kaddr", kn_addr, 16'd1024);

        // Reset mid-run, then restart from kernel 0 channel 0
        start_run(3'd0, 3'd0);
        consume(8, 1408, 0, 300, -1, got);
        chk("abort_point", got, 300);
        rst = 1'b1;
        #1;
        chk("abort_reset", {o_valid, busy, done, rd_en}, 4'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            seen = seen | done | o_valid;
        end
        chk("abort_no_done", seen, 1'b0);
        start_run(3'd0, 3'd0);
        consume(8, 1408, 0, -1, -1, got);
        chk("restart_count", got, 1408);
        finish_run();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
